// File: rtl/feature_packer_if.sv
// Serial feature stream in, packed vector strobe out.
interface feature_packer_if #(
  parameter int CL_IN = 8,
  parameter int N     = 3,
  parameter int IW    = $clog2(CL_IN)
);
  logic [N-1:0]       d_in;
  logic               en_in;
  logic               last_in;
  logic [CL_IN*N-1:0] d_out;
  logic               en_out;
  logic               pad_out;
  logic [IW-1:0]      idx_out;

  modport master (
    output d_in, en_in, last_in,
    input  d_out, en_out, pad_out, idx_out
  );

  modport slave (
    input  d_in, en_in, last_in,
    output d_out, en_out, pad_out, idx_out
  );
endinterface

// File: rtl/feature_packer.sv
// Packs CL_IN serial N-bit features into one vector for multi_adder,
// with early close via last_in and zero padding of the unfilled tail.
module feature_packer #(
  parameter int CL_IN = 8,
  parameter int N     = 3
) (
  input  logic              clk,
  input  logic              rst,
  feature_packer_if.slave   bus
);
  localparam int IW = $clog2(CL_IN);
  localparam int W  = CL_IN * N;
  localparam logic [IW-1:0] LAST = IW'(CL_IN - 1);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FILL  = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  buf_q;
  logic [W-1:0]  merged;
  logic          close;

  assign close = bus.en_in && (idx == LAST || bus.last_in);

  // Buffer is cleared on close, so slots above idx are already zero.
  always_comb begin
    merged = (state == FILL) ? buf_q : '0;
    merged[idx*N +: N] = bus.d_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      idx         <= '0;
      buf_q       <= '0;
      bus.d_out   <= '0;
      bus.en_out  <= 1'b0;
      bus.pad_out <= 1'b0;
    end else begin
      bus.en_out  <= 1'b0;
      bus.pad_out <= 1'b0;
      if (bus.en_in) begin
        if (close) begin
          bus.d_out   <= merged;
          bus.en_out  <= 1'b1;
          bus.pad_out <= (idx != LAST);
          idx         <= '0;
          buf_q       <= '0;
          state       <= EMPTY;
        end else begin
          buf_q <= merged;
          idx   <= idx + 1'b1;
          state <= FILL;
        end
      end
    end
  end

  assign bus.idx_out = idx;
endmodule

// File: tb/tb_feature_packer.sv
// Directed bench for feature_packer; expected strobes are queued by the
// stimulus and checked by an independent monitor.
module tb_feature_packer;
  localparam int CL_IN = 8;
  localparam int N     = 3;
  localparam int W     = CL_IN * N;

  typedef struct {
    logic [W-1:0] d;
    logic         pad;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic rst_d = 1'b1;
  logic [W-1:0] prev_d = '0;
  exp_t q[$];

  feature_packer_if #(.CL_IN(CL_IN), .N(N)) bus ();

  feature_packer #(.CL_IN(CL_IN), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %o, want %o (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_d) begin
      if (bus.en_out) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL strobe: unexpected en_out at cyc %0d, d_out %o",
                   cyc, bus.d_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("d_out", bus.d_out, e.d);
          chk("pad_out", W'(bus.pad_out), W'(e.pad));
          chk("strobe_cyc", W'(cyc), W'(e.cyc));
        end
      end else begin
        chk("pad_idle", W'(bus.pad_out), '0);
        chk("d_hold", bus.d_out, prev_d);
      end
    end
    prev_d = bus.d_out;
  end

  task automatic send(input logic [N-1:0] d, input logic en,
                      input logic last);
    @(posedge clk);
    #1;
    bus.d_in    = d;
    bus.en_in   = en;
    bus.last_in = last;
  endtask

  task automatic push(input logic [W-1:0] d, input logic pad);
    exp_t e;
    e.d   = d;
    e.pad = pad;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  initial begin
    rst         = 1'b1;
    bus.en_in   = 1'b1;
    bus.d_in    = 3'd5;
    bus.last_in = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_d_out", bus.d_out, '0);
      chk("rst_en_out", W'(bus.en_out), '0);
      chk("rst_idx", W'(bus.idx_out), '0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.en_in = 1'b0;

    // Full group, with fill index tracked each cycle
    for (int i = 0; i < 8; i++) begin
      send(3'((i + 1) % 8), 1'b1, 1'b0);
      chk("idx_fill", W'(bus.idx_out), W'(i));
    end
    push(24'o07654321, 1'b0);
    send(3'd0, 1'b0, 1'b0);
    chk("idx_after", W'(bus.idx_out), '0);

    // Back-to-back groups
    for (int i = 0; i < 16; i++) begin
      send(3'(i % 8), 1'b1, 1'b0);
      if (i % 8 == 7) push(24'o76543210, 1'b0);
    end
    send(3'd0, 1'b0, 1'b0);

    // Gapped input, stray last_in while idle
    for (int i = 0; i < 8; i++) begin
      send(3'((i + 1) % 8), 1'b1, 1'b0);
      if (i == 7) push(24'o07654321, 1'b0);
      send(3'd6, 1'b0, i == 3);
    end

    // Early close then fresh full group
    send(3'd5, 1'b1, 1'b0);
    send(3'd6, 1'b1, 1'b0);
    send(3'd7, 1'b1, 1'b1);
    push(24'o00000765, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(3'((i + 1) % 8), 1'b1, 1'b0);
      if (i == 7) push(24'o07654321, 1'b0);
    end
    send(3'd0, 1'b0, 1'b0);

    // Mid-group reset discards the partial group
    for (int i = 0; i < 4; i++) send(3'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.en_in = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_idx", W'(bus.idx_out), '0);
    chk("rst_mid_d", bus.d_out, '0);
    for (int i = 0; i < 8; i++) begin
      send(3'((i + 1) % 8), 1'b1, 1'b0);
      if (i == 7) push(24'o07654321, 1'b0);
    end
    send(3'd0, 1'b0, 1'b0);

    repeat (6) @(posedge clk);
    #1;
    chk("queue_empty", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/feature_packer.md
Name: feature_packer

Overview:
- Producer-side companion to multi_adder. Collects a serial stream of N-bit feature values, one per enabled cycle, into a CL_IN*N-bit parallel vector. Emits the vector with a one-cycle en_out strobe, in the d_in/en_in format that multi_adder consumes.
- Sits between a serial feature source (memory reader / previous layer output) and the multi_adder bank.
- Supports early group closure (last_in) with zero padding, so partial feature groups can be summed.

Parameters:
- CL_IN, 8, number of feature values per output vector (>=2)
- N, 3, width of each feature value in bits

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- d_in  in  N  serial feature value
- en_in  in  1  d_in valid this cycle, element accepted unconditionally
- last_in  in  1  qualified by en_in: current element closes the group
- d_out  out  CL_IN*N  packed vector, element i at d_out[i*N +: N]
- en_out  out  1  one-cycle strobe, d_out holds a new complete group
- pad_out  out  1  valid with en_out: group was closed early by last_in and zero-padded
- idx_out  out  clog2(CL_IN)  current fill index (debug/verification)

Behaviour:
- Reset (rst=1 at clk edge): d_out=0, en_out=0, pad_out=0, idx_out=0. Internal fill buffer is cleared. Any partial group is discarded. Reset overrides en_in in the same cycle.
- States:
  - EMPTY: idx=0, no partial data.
  - FILL: 0<idx<CL_IN.
  - EMPTY->FILL on en_in without close.
  - FILL->EMPTY on close.
  - EMPTY->EMPTY on close when CL_IN reached on the first element via last_in (single-element group).
- Accept: when en_in=1, buf[idx]<=d_in. First element of a group goes to index 0, ascending.
- Close condition: en_in=1 and (idx==CL_IN-1 or last_in=1).
- On close:
  - Next cycle: d_out = buffer contents including the closing element; positions >idx are forced to 0; en_out=1.
  - pad_out=1 iff idx<CL_IN-1 at close.
  - idx returns to 0 and the buffer is cleared in the same edge.
- Latency: en_out rises exactly one cycle after the closing element's accept edge.
- Throughput: one element per cycle with no bubbles. The element following a close is accepted into index 0 on the very next cycle. Two full groups back-to-back produce en_out pulses exactly CL_IN cycles apart.
- en_out is high for exactly one cycle per group and never asserted without a close.
- pad_out is 0 whenever en_out=0.
- d_out holds its last value until the next close. It does not change while a group is filling.
- en_in=0: no state change, last_in ignored.
- last_in with idx==CL_IN-1: normal full close, pad_out=0.
- No backpressure: downstream must accept every en_out strobe, matching multi_adder.
- Values are passed unmodified; no arithmetic, no sign handling.

Test Plan (CL_IN=8, N=3):
1. Reset: hold rst for 2 cycles with en_in=1, d_in=3'd5 -> d_out=0, en_out=0, idx_out=0 throughout. The first post-reset element lands at index 0.
2. Full group: en_in=1 for 8 cycles, d_in=1,2,3,4,5,6,7,0 -> single en_out pulse one cycle after the 8th accept, pad_out=0. d_out[2:0]=1, d_out[5:3]=2, ..., d_out[20:18]=7, d_out[23:21]=0, i.e. d_out=24'o07654321.
3. Back-to-back: 16 continuous elements, d_in=i mod 8 -> en_out pulses at cycles 9 and 17 after the first accept, both vectors 24'o76543210. d_out is stable between pulses.
4. Gapped input: same 8 values as scenario 2 with en_in deasserted every other cycle -> identical d_out. en_out comes one cycle after the 8th accepted element. A last_in pulse during an en_in=0 cycle has no effect.
5. Early close: d_in=5,6,7 with last_in on the 3rd -> en_out=1, pad_out=1, d_out=24'o00000765. The next 8 elements 1..8 mod 8 form a fresh full group with pad_out=0.
6. Mid-group reset: accept 4 elements (7,7,7,7), assert rst 1 cycle, then feed 1..8 mod 8 -> single en_out with d_out=24'o07654321. No 7s remain and no extra strobe appears.
